// File: rtl/hub_wr_arbiter_pkg.sv
// Shared types for the hub register write-port arbiter.
// The hub address prefix itself remains a parameter of the top level.
package hub_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// It searches upward from last_grant+1 with wrap-around and returns a one-hot winner.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    int   idx_s;
    logic hit_s;

    // The first requester after last_grant, in circular order, takes the grant
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx_s  = 0;
        hit_s  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s         = (int'(last_grant) + k) % NUM_REQ;
            hit_s         = ~valid & req[idx_s];
            winner[idx_s] = winner[idx_s] | hit_s;
            valid         = valid | hit_s;
        end
    end

endmodule

// File: rtl/hub_wr_arbiter.sv
// Round-robin write-port arbiter for the hub register memory, with burst locking
// and a forced release after MAX_BURST accepted quadlets.
module hub_wr_arbiter
    import hub_wr_arbiter_pkg::*;
#(
    parameter int         NUM_REQ   = 2,
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] ADDR_HUB  = 4'h2
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*9-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_last,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic                  reg_wen,
    output logic [15:0]           reg_waddr,
    output logic [31:0]           reg_wdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t           state_r, state_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s;
    logic                 busy_r, busy_s;
    logic [IDX_W-1:0]     last_grant_r, last_grant_s;
    logic [CNT_W-1:0]     burst_cnt_r, burst_cnt_s;
    logic [NUM_REQ-1:0]   pick_s;
    logic                 pick_valid_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 accept_s;
    logic                 own_last_s;
    logic [8:0]           sel_addr_s;
    logic [31:0]          sel_data_s;
    logic                 reg_wen_r;
    logic [15:0]          reg_waddr_r;
    logic [31:0]          reg_wdata_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_r),
        .winner     (pick_s),
        .valid      (pick_valid_s)
    );

    assign ack        = gnt_r & req;
    assign accept_s   = |ack;
    assign own_last_s = |(gnt_r & req_last);

    // Owner index and write payload, selected by the one-hot grant
    always_comb begin
        gnt_idx_s  = '0;
        sel_addr_s = 9'd0;
        sel_data_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_idx_s  = gnt_idx_s  | (gnt_r[i] ? IDX_W'(i) : IDX_W'(0));
            sel_addr_s = sel_addr_s | (gnt_r[i] ? req_addr[9*i +: 9]   : 9'd0);
            sel_data_s = sel_data_s | (gnt_r[i] ? req_data[32*i +: 32] : 32'd0);
        end
    end

    // Arbitration FSM next state; any non-continuing BURST cycle is a release
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        busy_s       = busy_r;
        burst_cnt_s  = burst_cnt_r;
        last_grant_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_s       = pick_s;
                    busy_s      = 1'b1;
                    burst_cnt_s = '0;
                    state_s     = ST_BURST;
                end else begin
                    gnt_s  = '0;
                    busy_s = 1'b0;
                end
            end
            ST_BURST: begin
                if (accept_s && !own_last_s && (burst_cnt_r != CNT_W'(MAX_BURST - 1))) begin
                    burst_cnt_s = burst_cnt_r + CNT_W'(1);
                end else begin
                    gnt_s        = '0;
                    busy_s       = 1'b0;
                    burst_cnt_s  = '0;
                    last_grant_s = gnt_idx_s;
                    state_s      = ST_IDLE;
                end
            end
            default: begin
                gnt_s       = '0;
                busy_s      = 1'b0;
                burst_cnt_s = '0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant and burst bookkeeping registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            gnt_r        <= '0;
            busy_r       <= 1'b0;
            burst_cnt_r  <= '0;
            last_grant_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r      <= state_s;
            gnt_r        <= gnt_s;
            busy_r       <= busy_s;
            burst_cnt_r  <= burst_cnt_s;
            last_grant_r <= last_grant_s;
        end
    end

    // Hub memory write port; address and data hold when nothing is accepted
    always_ff @(posedge sysclk) begin
        if (reset) begin
            reg_wen_r   <= 1'b0;
            reg_waddr_r <= 16'd0;
            reg_wdata_r <= 32'd0;
        end else begin
            reg_wen_r <= accept_s;
            if (accept_s) begin
                reg_waddr_r <= {ADDR_HUB, 3'b000, sel_addr_s};
                reg_wdata_r <= sel_data_s;
            end else begin
                reg_waddr_r <= reg_waddr_r;
                reg_wdata_r <= reg_wdata_r;
            end
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign reg_wen   = reg_wen_r;
    assign reg_waddr = reg_waddr_r;
    assign reg_wdata = reg_wdata_r;

endmodule

// File: tb/tb_hub_wr_arbiter.sv
// Directed bench for hub_wr_arbiter: a small requester model drives bursts and
// each scenario task compares grants and hub writes against hand-derived values.
module tb_hub_wr_arbiter;

    localparam int         NREQ = 2;
    localparam int         MAXB = 16;
    localparam logic [3:0] HUB  = 4'h2;

    logic              sysclk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req, req_last, gnt, ack;
    logic [NREQ*9-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic              busy, reg_wen;
    logic [15:0]       reg_waddr;
    logic [31:0]       reg_wdata;

    int checks = 0;
    int errors = 0;

    int          rem [NREQ];
    int          acc [NREQ];
    int          drop_at [NREQ];
    logic [8:0]  cur_addr [NREQ];
    logic [31:0] dbase [NREQ];

    logic [1:0]  s_gnt, s_ack;
    logic        s_busy, s_wen;
    logic [15:0] s_waddr;
    logic [31:0] s_wdata;
    logic [1:0]  gnt_log [$];
    logic [1:0]  ack_log [$];
    logic [15:0] wq_addr [$];
    logic [31:0] wq_data [$];

    always #5 sysclk = ~sysclk;

    hub_wr_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_BURST (MAXB),
        .ADDR_HUB  (HUB)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_last  (req_last),
        .gnt       (gnt),
        .ack       (ack),
        .busy      (busy),
        .reg_wen   (reg_wen),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata)
    );

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]               = (rem[i] > 0);
            req_last[i]          = (rem[i] == 1);
            req_addr[9*i +: 9]   = cur_addr[i];
            req_data[32*i +: 32] = dbase[i] + 32'(acc[i]);
        end
    endtask

    // Sample on the falling edge, then advance the requesters just after the rising edge
    task automatic cycle();
        @(negedge sysclk);
        s_gnt = gnt; s_ack = ack; s_busy = busy;
        s_wen = reg_wen; s_waddr = reg_waddr; s_wdata = reg_wdata;
        gnt_log.push_back(gnt);
        ack_log.push_back(ack);
        if (reg_wen === 1'b1) begin
            wq_addr.push_back(reg_waddr);
            wq_data.push_back(reg_wdata);
        end
        @(posedge sysclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack[i] === 1'b1) begin
                cur_addr[i] = cur_addr[i] + 9'd1;
                acc[i]      = acc[i] + 1;
                rem[i]      = rem[i] - 1;
                if (drop_at[i] != 0 && acc[i] == drop_at[i]) rem[i] = 0;
            end
        end
        drive();
    endtask

    task automatic start(input int i, input logic [8:0] a, input int len,
                         input logic [31:0] d, input int drop);
        cur_addr[i] = a; rem[i] = len; acc[i] = 0; dbase[i] = d; drop_at[i] = drop;
        drive();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0; acc[i] = 0; drop_at[i] = 0; cur_addr[i] = 9'd0; dbase[i] = 32'd0;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        cycle();
        cycle();
        reset = 1'b0;
        gnt_log.delete(); ack_log.delete(); wq_addr.delete(); wq_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        cycle();
        checks++; if (s_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b expected %b", s_gnt, 2'b00); end
        checks++; if (s_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b expected %b", s_ack, 2'b00); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", s_busy); end
        checks++; if (s_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b expected 0", s_wen); end
        checks++; if (s_waddr !== 16'h0000) begin errors++; $display("FAIL reset_waddr got %h expected 0000", s_waddr); end
        checks++; if (s_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h expected 00000000", s_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        start(0, 9'h005, 1, 32'hDEADBEEF, 0);
        cycle();
        checks++; if (s_gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_pre got %b expected 00", s_gnt); end
        cycle();
        checks++; if (s_gnt !== 2'b01 || s_ack !== 2'b01 || s_busy !== 1'b1 || s_wen !== 1'b0) begin
            errors++; $display("FAIL single_grant got gnt=%b ack=%b busy=%b wen=%b expected 01 01 1 0", s_gnt, s_ack, s_busy, s_wen);
        end
        cycle();
        checks++; if (s_gnt !== 2'b00 || s_busy !== 1'b0) begin
            errors++; $display("FAIL single_release got gnt=%b busy=%b expected 00 0", s_gnt, s_busy);
        end
        checks++; if (s_wen !== 1'b1 || s_waddr !== {HUB, 3'b000, 9'h005} || s_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_write got wen=%b addr=%h data=%h expected 1 2005 deadbeef", s_wen, s_waddr, s_wdata);
        end
        cycle();
        checks++; if (s_wen !== 1'b0 || s_waddr !== 16'h2005) begin
            errors++; $display("FAIL single_wen_drop got wen=%b addr=%h expected 0 2005", s_wen, s_waddr);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0]  exp_g [15];
        logic [8:0]  exp_a [8];
        logic [31:0] exp_d [8];
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                  2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        exp_a = '{9'h010, 9'h011, 9'h012, 9'h020, 9'h021, 9'h022, 9'h030, 9'h031};
        exp_d = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hB0000000,
                  32'hB0000001, 32'hB0000002, 32'hA1000000, 32'hB1000000};
        do_reset();
        start(0, 9'h010, 3, 32'hA0000000, 0);
        start(1, 9'h020, 3, 32'hB0000000, 0);
        for (int c = 0; c < 9; c++) cycle();
        start(0, 9'h030, 1, 32'hA1000000, 0);
        start(1, 9'h031, 1, 32'hB1000000, 0);
        for (int c = 0; c < 6; c++) cycle();
        for (int k = 0; k < 15; k++) begin
            checks++; if (gnt_log[k] !== exp_g[k]) begin
                errors++; $display("FAIL sim_gnt[%0d] got %b expected %b", k, gnt_log[k], exp_g[k]);
            end
        end
        checks++; if (wq_addr.size() != 8) begin
            errors++; $display("FAIL sim_write_count got %0d expected 8", wq_addr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (wq_addr[k] !== {HUB, 3'b000, exp_a[k]} || wq_data[k] !== exp_d[k]) begin
                    errors++; $display("FAIL sim_write[%0d] got %h/%h expected %h/%h", k, wq_addr[k], wq_data[k], {HUB, 3'b000, exp_a[k]}, exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_forced_release();
        int n_own;
        do_reset();
        start(1, 9'h100, 20, 32'hC0000000, 0);
        for (int c = 0; c < 26; c++) cycle();
        checks++; if (gnt_log[16] !== 2'b10 || gnt_log[17] !== 2'b00 || gnt_log[18] !== 2'b10) begin
            errors++; $display("FAIL forced_gap got %b %b %b expected 10 00 10", gnt_log[16], gnt_log[17], gnt_log[18]);
        end
        checks++; if (gnt_log[21] !== 2'b10 || gnt_log[22] !== 2'b00) begin
            errors++; $display("FAIL forced_tail got %b %b expected 10 00", gnt_log[21], gnt_log[22]);
        end
        n_own = 0;
        foreach (gnt_log[k]) if (gnt_log[k] === 2'b10) n_own++;
        checks++; if (n_own != 20) begin
            errors++; $display("FAIL forced_grant_cycles got %0d expected 20", n_own);
        end
        checks++; if (wq_addr.size() != 20) begin
            errors++; $display("FAIL forced_write_count got %0d expected 20", wq_addr.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                checks++; if (wq_addr[k] !== {HUB, 3'b000, 9'h100 + 9'(k)} || wq_data[k] !== 32'hC0000000 + 32'(k)) begin
                    errors++; $display("FAIL forced_write[%0d] got %h/%h expected %h/%h", k, wq_addr[k], wq_data[k],
                                       {HUB, 3'b000, 9'h100 + 9'(k)}, 32'hC0000000 + 32'(k));
                end
            end
        end
    endtask

    task automatic test_starvation();
        int  waited;
        logic seen;
        do_reset();
        start(0, 9'h000, 40, 32'h11110000, 0);
        cycle();
        cycle();
        start(1, 9'h1F0, 1, 32'h22220000, 0);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 40) begin
            cycle();
            waited++;
            if (s_gnt[1] === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || waited > MAXB + 1) begin
            errors++; $display("FAIL starvation_wait got seen=%b cycles=%0d expected 1 and <=%0d", seen, waited, MAXB + 1);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        start(0, 9'h080, 10, 32'hD0000000, 2);
        start(1, 9'h090, 1, 32'hE0000000, 0);
        for (int c = 0; c < 8; c++) cycle();
        checks++; if (gnt_log[3] !== 2'b01 || ack_log[3] !== 2'b00) begin
            errors++; $display("FAIL abandon_drop got gnt=%b ack=%b expected 01 00", gnt_log[3], ack_log[3]);
        end
        checks++; if (gnt_log[4] !== 2'b00 || gnt_log[5] !== 2'b10) begin
            errors++; $display("FAIL abandon_regrant got %b %b expected 00 10", gnt_log[4], gnt_log[5]);
        end
        checks++; if (wq_addr.size() != 3) begin
            errors++; $display("FAIL abandon_write_count got %0d expected 3", wq_addr.size());
        end else begin
            checks++; if (wq_addr[0] !== {HUB, 3'b000, 9'h080} || wq_addr[1] !== {HUB, 3'b000, 9'h081}
                          || wq_addr[2] !== {HUB, 3'b000, 9'h090}) begin
                errors++; $display("FAIL abandon_addrs got %h %h %h expected 2080 2081 2090", wq_addr[0], wq_addr[1], wq_addr[2]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        start(0, 9'h040, 10, 32'hF0000000, 0);
        for (int c = 0; c < 6; c++) cycle();
        reset = 1'b1;
        cycle();
        checks++; if (s_wen !== 1'b1 || s_waddr !== {HUB, 3'b000, 9'h044}) begin
            errors++; $display("FAIL midrst_fifth_write got wen=%b addr=%h expected 1 2044", s_wen, s_waddr);
        end
        reset = 1'b0;
        start(1, 9'h0A0, 1, 32'h33330000, 0);
        cycle();
        checks++; if (s_gnt !== 2'b00 || s_busy !== 1'b0 || s_wen !== 1'b0) begin
            errors++; $display("FAIL midrst_clear got gnt=%b busy=%b wen=%b expected 00 0 0", s_gnt, s_busy, s_wen);
        end
        cycle();
        checks++; if (s_gnt !== 2'b01) begin
            errors++; $display("FAIL midrst_first_grant got %b expected 01", s_gnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_model();
        test_reset();
        test_single();
        test_simultaneous();
        test_forced_release();
        test_starvation();
        test_abandon();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub_wr_arbiter.md
# hub_wr_arbiter

Write-port arbiter for the hub register memory. Shares the single hub memory write port among NUM_REQ requesters, e.g. the FireWire broadcast receiver and the local status snapshot writer. Uses round-robin arbitration with burst locking and a maximum-burst limit. Drives the existing hub register write interface (reg_wen / reg_waddr / reg_wdata) with registered outputs.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4
- MAX_BURST, 16: maximum accepted writes per grant before forced release, legal range 1..64
- sysclk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request; held while data is valid
- req_addr  in  NUM_REQ*9  per-requester quadlet address; requester i owns bits [9i+8:9i]
- req_data  in  NUM_REQ*32  per-requester write data; requester i owns bits [32i+31:32i]
- req_last  in  NUM_REQ  marks the final quadlet of a burst
- gnt  out  NUM_REQ  registered one-hot grant, or zero
- ack  out  NUM_REQ  combinational gnt & req; one quadlet accepted this cycle
- busy  out  1  registered; high while any grant is held
- reg_wen  out  1  hub memory write enable
- reg_waddr  out  16  hub memory write address
- reg_wdata  out  32  hub memory write data

## Operation
- States: IDLE and BURST.
- IDLE:
  - If any req is high, pick the winner round-robin, searching from last_grant+1 upward with wrap.
  - Register the winner as one-hot gnt, set busy, clear burst_cnt, go to BURST.
  - If no req, stay in IDLE with gnt=0.
- BURST, owner i:
  - Each cycle with req[i]=1, one quadlet is accepted (ack[i]=1) and burst_cnt increments.
  - Release when an accept occurs with req_last[i]=1 or burst_cnt==MAX_BURST-1.
  - Release also when req[i]=0 (abandoned burst); no write is issued in that cycle.
- On release:
  - gnt goes to 0 next cycle, busy goes low, last_grant<=i, return to IDLE.
- Write output, registered one cycle after accept:
  - reg_wen<=|ack
  - reg_waddr<={ADDR_HUB, 3'b000, req_addr[i]}
  - reg_wdata<=req_data[i]
- When no accept occurs, reg_wen<=0. reg_waddr and reg_wdata hold their last values.
- A forced release at MAX_BURST does not drop data. The requester keeps req high, re-arbitrates, and continues the burst after its next grant.
- Simultaneous requests in IDLE are resolved purely by round-robin. No requester is granted twice in a row while another is requesting.
- Reset mid-burst: all state clears in the same edge. A write already in the output register is discarded (reg_wen=0 after reset).
- Outputs at reset: gnt=0, ack=0, busy=0, reg_wen=0, reg_waddr=0, reg_wdata=0, last_grant=NUM_REQ-1, so requester 0 wins first. burst_cnt=0, state=IDLE.

## Timing
- Arbitration latency is 1 cycle: req rising at edge N gives gnt at N+1 and the first ack in cycle N+1.
- Write latency is 1 cycle: an ack in cycle K gives reg_wen=1 in cycle K+1.
- Sustained throughput is one quadlet per cycle within a burst.
- Exactly one IDLE cycle (gnt=0) separates consecutive grants. Minimum cost per burst is burst length + 1 cycles.
- Worst-case wait for a requester is (NUM_REQ-1)*(MAX_BURST+1) cycles.
- burst_cnt width: $clog2(MAX_BURST)+1 bits; it never wraps because release occurs at MAX_BURST-1.
- Requester rules: addr, data and last must be stable in any cycle where req is high. The requester may change them on the cycle after ack.

## Structure
- ADDR_HUB stays in the shared Constants.v. No new package constants.
- Sub-module rr_pick:
  - Combinational round-robin picker.
  - Inputs: req vector and last_grant index.
  - Outputs: one-hot winner and a valid flag.
  - Parameterized by NUM_REQ and reusable by other hub arbiters.
- The top level holds the FSM, burst_cnt, last_grant and the output registers.

## Test plan
- **Single write:** req[0]=1, addr=0x005, data=0xDEADBEEF, last=1 → gnt=01 one cycle later; reg_wen=1 one cycle after that with reg_waddr={ADDR_HUB,3'b0,9'h005} and reg_wdata=0xDEADBEEF; busy low afterwards.
- **Simultaneous requests:** req=11 from reset, each sending 3-quadlet bursts → requester 0 gets 3 writes, then one idle cycle, then requester 1 gets 3 writes; the next contest is won by requester 0.
- **Forced release:** requester 1 sends a 20-quadlet burst with requester 0 idle → 16 writes, release, re-grant to requester 1, 4 writes; all 20 addresses are written in order.
- **Starvation bound:** requester 0 streams continuously while requester 1 requests → requester 1 is granted within MAX_BURST+1 cycles.
- **Abandon:** requester 0 drops req after 2 accepts without last → exactly 2 writes; gnt clears next cycle; requester 1 is granted in the following arbitration.
- **Reset mid-burst:** assert reset during the 5th write → the next cycle shows gnt=0, busy=0, reg_wen=0; after reset the first grant goes to requester 0.
